fetch_unit: RTL and testbench
=============================

# fetch_unit

Instruction-fetch stage of the pipelined processor. It owns the program counter, boots it from the reset vector in instruction memory, and drives the instruction memory read port. Each cycle it presents `instruction`, `pc`, `nextPC`, `iamBubble` and `flush` to the IF/ID pipeline buffer, which registers them. It inserts bubbles on stall, redirect and halt, and it accepts PC redirects from branch resolution.

## Interface
- `PC_WIDTH`, 32, program counter and memory address width.
- `INSTR_WIDTH`, 16, instruction and memory word width.
- `HLT_OPCODE`, 5'b00001, value of `instruction[15:11]` that halts fetch.
- `clk` in 1: single clock; all state updates occur on the rising edge.
- `rst` in 1: synchronous reset, active-high.
- `stall` in 1: hazard unit request to hold the PC and emit a bubble.
- `redirect_valid` in 1: a taken branch, jump or return was resolved downstream.
- `redirect_pc` in 32: target address, valid when `redirect_valid`=1.
- `imem_addr` out 32: word address to instruction memory.
- `imem_data` in 16: memory word at `imem_addr`, asynchronous (same-cycle) read.
- `instruction` out 16: fetched word, or 0 when a bubble is emitted.
- `pc` out 32: address of `instruction`, or 0 when a bubble is emitted.
- `nextPC` out 32: `pc`+1, or 0 when a bubble is emitted.
- `iamBubble` out 1: this cycle's IF/ID payload is a bubble.
- `flush` out 1: clear the IF/ID buffer; equals `redirect_valid` while in RUN or HALTED.

## Operation
- State register has four states: BOOT_LO, BOOT_HI, RUN, HALTED. It also holds PC (32 bits) and `lo_half` (16 bits).
- BOOT_LO
  - Drives `imem_addr`=0.
  - Captures `lo_half` <= `imem_data`.
  - Next state is BOOT_HI.
- BOOT_HI
  - Drives `imem_addr`=1.
  - Loads PC <= {`imem_data`, `lo_half`}.
  - Next state is RUN.
  - Both boot states emit a bubble, and `stall`/`redirect_valid` are ignored in them.
- RUN: `imem_addr`=PC. The edge update follows this priority order:
  1. `redirect_valid`: PC <= `redirect_pc`. The current word is discarded as a bubble and `flush`=1.
  2. `stall`: PC holds and a bubble is emitted.
  3. Fetched opcode == `HLT_OPCODE`: the HLT word is emitted normally, PC <= PC+1, and the next state is HALTED.
  4. Otherwise the word is emitted normally and PC <= PC+1.
- Normal emission drives `instruction`=`imem_data`, `pc`=PC, `nextPC`=PC+1 and `iamBubble`=0.
- A bubble drives `instruction`=0, `pc`=0, `nextPC`=0 and `iamBubble`=1.
- HALTED
  - Emits a bubble every cycle and holds PC, with `imem_addr`=PC.
  - `redirect_valid` loads PC <= `redirect_pc`, asserts `flush`=1 and moves to RUN.
  - `stall` has no effect.
- PC arithmetic is modulo 2^32: 0xFFFFFFFF+1 = 0x00000000, and `nextPC` wraps identically.
- All outputs are combinational from the state, PC and `imem_data`. The IF/ID buffer provides the pipeline register.

## Timing
- `rst`=1 at an edge sets state <= BOOT_LO, PC <= 0 and `lo_half` <= 0, regardless of any other input.
  - While in BOOT_LO, outputs are bubble values, `imem_addr`=0 and `flush`=0.
- The first real instruction appears on the outputs in the third cycle after reset deasserts (BOOT_LO, BOOT_HI, RUN).
- Redirect latency:
  - `redirect_valid` sampled at edge N makes `pc`=`redirect_pc` valid in cycle N+1.
  - The cycle that carries `redirect_valid` always emits a bubble with `flush`=1.
- Stall covers exactly the cycles during which `stall`=1. The word at PC is re-fetched in the first cycle after `stall` drops.
- Redirect and stall in the same cycle: redirect wins. PC loads the target and the cycle emits a flush plus bubble.
- Reset mid-operation (RUN or HALTED) discards PC and restarts boot. Any pending redirect is lost.
- Redirect to an address holding HLT: that HLT executes normally in the following cycle.

## Test plan
- Boot: M[0]=0x0010, M[1]=0x0000, then deassert `rst`.
  - Two bubble cycles with `imem_addr`=0 then 1.
  - Third cycle: `pc`=0x10, `nextPC`=0x11, `iamBubble`=0.
- Sequential fetch: M[0x10..0x12]=0x1111/0x2222/0x3333 gives `instruction` 0x1111, 0x2222, 0x3333 on consecutive cycles with `pc` 0x10, 0x11, 0x12.
- Stall at `pc`=0x11 for 2 cycles:
  - Two bubbles (`instruction`=0, `pc`=0, `iamBubble`=1) while `imem_addr` holds 0x11.
  - Then `instruction`=0x2222 at `pc`=0x11.
- Redirect with `redirect_pc`=0x40 asserted together with `stall`:
  - That cycle has `flush`=1 and `iamBubble`=1.
  - Next cycle `pc`=0x40.
- HLT: M[0x20]=0x0800 (opcode 00001).
  - Word 0x0800 is emitted with `pc`=0x20.
  - Then bubbles indefinitely with `imem_addr`=0x21, with `stall` toggling without effect.
  - A redirect to 0x50 resumes fetch at `pc`=0x50.
- Wrap and reset:
  - A redirect to 0xFFFFFFFF yields `nextPC`=0 and `pc`=0 on the next cycle.
  - Asserting `rst` during RUN restarts the BOOT_LO/BOOT_HI sequence.

Source files
------------

// File: rtl/fetch_if.sv
// Fetch-stage bus: hazard/redirect inputs, instruction memory port and IF/ID payload.
interface fetch_if #(
    parameter int unsigned PC_WIDTH    = 32,
    parameter int unsigned INSTR_WIDTH = 16
) ();
    logic                   stall;
    logic                   redirect_valid;
    logic [PC_WIDTH-1:0]    redirect_pc;
    logic [PC_WIDTH-1:0]    imem_addr;
    logic [INSTR_WIDTH-1:0] imem_data;
    logic [INSTR_WIDTH-1:0] instruction;
    logic [PC_WIDTH-1:0]    pc;
    logic [PC_WIDTH-1:0]    nextPC;
    logic                   iamBubble;
    logic                   flush;

    // Fetch unit side
    modport master (
        input  stall, redirect_valid, redirect_pc, imem_data,
        output imem_addr, instruction, pc, nextPC, iamBubble, flush
    );

    // Pipeline / memory side
    modport slave (
        output stall, redirect_valid, redirect_pc, imem_data,
        input  imem_addr, instruction, pc, nextPC, iamBubble, flush
    );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch: boots the PC from memory words 0/1, then fetches sequentially,
// inserting bubbles on stall, redirect and halt. Outputs are combinational; the IF/ID
// buffer downstream provides the pipeline register.
module fetch_unit #(
    parameter int unsigned PC_WIDTH    = 32,
    parameter int unsigned INSTR_WIDTH = 16,
    parameter logic [4:0]  HLT_OPCODE  = 5'b00001
) (
    input  logic      clk,
    input  logic      rst,
    fetch_if.master   bus
);

    typedef enum logic [1:0] {
        BOOT_LO = 2'd0,
        BOOT_HI = 2'd1,
        RUN     = 2'd2,
        HALTED  = 2'd3
    } state_t;

    state_t                 r_state;
    logic [PC_WIDTH-1:0]    r_pc;
    logic [INSTR_WIDTH-1:0] r_lo_half;

    logic [PC_WIDTH-1:0]    w_pc_inc;
    logic                   w_is_hlt;
    logic                   w_emit;

    assign w_pc_inc = r_pc + PC_WIDTH'(1);
    assign w_is_hlt = (bus.imem_data[INSTR_WIDTH-1 -: 5] == HLT_OPCODE);

    // Decide whether this cycle emits the fetched word or a bubble
    always_comb begin
        w_emit = 1'b0;
        if (r_state == RUN && !bus.redirect_valid && !bus.stall) begin
            w_emit = 1'b1;
        end
    end

    // Memory address and IF/ID payload
    always_comb begin
        bus.imem_addr   = r_pc;
        bus.instruction = '0;
        bus.pc          = '0;
        bus.nextPC      = '0;
        bus.iamBubble   = 1'b1;
        bus.flush       = 1'b0;
        case (r_state)
            BOOT_LO: bus.imem_addr = PC_WIDTH'(0);
            BOOT_HI: bus.imem_addr = PC_WIDTH'(1);
            RUN,
            HALTED:  bus.flush     = bus.redirect_valid;
            default: bus.imem_addr = r_pc;
        endcase
        if (w_emit) begin
            bus.instruction = bus.imem_data;
            bus.pc          = r_pc;
            bus.nextPC      = w_pc_inc;
            bus.iamBubble   = 1'b0;
        end
    end

    // State, PC and boot-half registers; redirect beats stall beats halt detection
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= BOOT_LO;
            r_pc      <= '0;
            r_lo_half <= '0;
        end else begin
            case (r_state)
                BOOT_LO: begin
                    r_lo_half <= bus.imem_data;
                    r_state   <= BOOT_HI;
                end
                BOOT_HI: begin
                    r_pc    <= PC_WIDTH'({bus.imem_data, r_lo_half});
                    r_state <= RUN;
                end
                RUN: begin
                    if (bus.redirect_valid) begin
                        r_pc <= bus.redirect_pc;
                    end else if (!bus.stall) begin
                        r_pc <= w_pc_inc;
                        if (w_is_hlt) begin
                            r_state <= HALTED;
                        end
                    end
                end
                HALTED: begin
                    if (bus.redirect_valid) begin
                        r_pc    <= bus.redirect_pc;
                        r_state <= RUN;
                    end
                end
                default: r_state <= BOOT_LO;
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: stimulus pushes hand-computed expectations per cycle,
// a negedge monitor pops and compares against the DUT outputs.
module tb_fetch_unit;

    logic clk;
    logic rst;

    fetch_if #(.PC_WIDTH(32), .INSTR_WIDTH(16)) bus ();

    fetch_unit #(.PC_WIDTH(32), .INSTR_WIDTH(16), .HLT_OPCODE(5'b00001)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct packed {
        logic [7:0]  id;
        logic [31:0] addr;
        logic [15:0] instr;
        logic [31:0] pc;
        logic [31:0] npc;
        logic        bub;
        logic        fl;
    } exp_t;

    exp_t        sb_q[$];
    logic [15:0] mem [0:255];
    int          checks = 0;
    int          errors = 0;

    // Small memory; only low address byte decoded (0xFFFFFFFF maps to entry 0xFF)
    assign bus.imem_data = mem[bus.imem_addr[7:0]];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Monitor: compare every presented cycle against the queued expectation
    always @(negedge clk) begin
        if (sb_q.size() > 0) begin
            exp_t e;
            exp_t a;
            e = sb_q.pop_front();
            a = '{id: e.id, addr: bus.imem_addr, instr: bus.instruction, pc: bus.pc,
                  npc: bus.nextPC, bub: bus.iamBubble, fl: bus.flush};
            checks++;
            if (a !== e) begin
                errors++;
                $display("FAIL step%0d actual addr=%h instr=%h pc=%h npc=%h bub=%b fl=%b required addr=%h instr=%h pc=%h npc=%h bub=%b fl=%b",
                         e.id, a.addr, a.instr, a.pc, a.npc, a.bub, a.fl,
                         e.addr, e.instr, e.pc, e.npc, e.bub, e.fl);
            end
        end
    end

    // Drive one cycle of inputs, queue its expected outputs, advance to just past the edge
    task automatic step(input logic [7:0] id, input logic r, input logic st, input logic rv,
                        input logic [31:0] rpc, input logic [31:0] addr, input logic [15:0] instr,
                        input logic [31:0] pc, input logic [31:0] npc, input logic bub,
                        input logic fl);
        rst                = r;
        bus.stall          = st;
        bus.redirect_valid = rv;
        bus.redirect_pc    = rpc;
        sb_q.push_back('{id: id, addr: addr, instr: instr, pc: pc, npc: npc, bub: bub, fl: fl});
        @(posedge clk);
        #1;
    endtask

    // Normal-emission shorthand
    task automatic emit(input logic [7:0] id, input logic [31:0] a, input logic [15:0] w);
        step(id, 1'b0, 1'b0, 1'b0, 32'h0, a, w, a, a + 32'd1, 1'b0, 1'b0);
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 16'h0000;
        mem[8'h00] = 16'h0010;
        mem[8'h01] = 16'h0000;
        mem[8'h10] = 16'h1111;
        mem[8'h11] = 16'h2222;
        mem[8'h12] = 16'h3333;
        mem[8'h13] = 16'h4444;
        mem[8'h20] = 16'h0800;
        mem[8'h21] = 16'h9999;
        mem[8'h40] = 16'h5555;
        mem[8'h41] = 16'h6666;
        mem[8'h50] = 16'hAAAA;
        mem[8'hFF] = 16'h7777;

        rst                = 1'b1;
        bus.stall          = 1'b0;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc    = 32'h0;
        @(posedge clk);
        #1;

        // Reset held: BOOT_LO bubble at address 0
        step(8'd1,  1'b1, 1'b0, 1'b0, 32'h0,  32'h0,  16'h0, 32'h0, 32'h0, 1'b1, 1'b0);
        // Boot states ignore stall and redirect
        step(8'd2,  1'b0, 1'b1, 1'b1, 32'h40, 32'h0,  16'h0, 32'h0, 32'h0, 1'b1, 1'b0);
        step(8'd3,  1'b0, 1'b1, 1'b1, 32'h40, 32'h1,  16'h0, 32'h0, 32'h0, 1'b1, 1'b0);
        // Sequential fetch from boot vector 0x10
        emit(8'd4,  32'h10, 16'h1111);
        // Two-cycle stall at 0x11, then re-fetch
        step(8'd5,  1'b0, 1'b1, 1'b0, 32'h0,  32'h11, 16'h0, 32'h0, 32'h0, 1'b1, 1'b0);
        step(8'd6,  1'b0, 1'b1, 1'b0, 32'h0,  32'h11, 16'h0, 32'h0, 32'h0, 1'b1, 1'b0);
        emit(8'd7,  32'h11, 16'h2222);
        emit(8'd8,  32'h12, 16'h3333);
        // Redirect together with stall: redirect wins
        step(8'd9,  1'b0, 1'b1, 1'b1, 32'h40, 32'h13, 16'h0, 32'h0, 32'h0, 1'b1, 1'b1);
        emit(8'd10, 32'h40, 16'h5555);
        // Redirect onto a HLT word; it executes normally
        step(8'd11, 1'b0, 1'b0, 1'b1, 32'h20, 32'h41, 16'h0, 32'h0, 32'h0, 1'b1, 1'b1);
        emit(8'd12, 32'h20, 16'h0800);
        // Halted: bubbles at 0x21, stall toggling has no effect
        step(8'd13, 1'b0, 1'b1, 1'b0, 32'h0,  32'h21, 16'h0, 32'h0, 32'h0, 1'b1, 1'b0);
        step(8'd14, 1'b0, 1'b0, 1'b0, 32'h0,  32'h21, 16'h0, 32'h0, 32'h0, 1'b1, 1'b0);
        step(8'd15, 1'b0, 1'b1, 1'b0, 32'h0,  32'h21, 16'h0, 32'h0, 32'h0, 1'b1, 1'b0);
        // Redirect out of HALTED resumes at 0x50
        step(8'd16, 1'b0, 1'b1, 1'b1, 32'h50, 32'h21, 16'h0, 32'h0, 32'h0, 1'b1, 1'b1);
        emit(8'd17, 32'h50, 16'hAAAA);
        // Wrap: redirect to 0xFFFFFFFF, nextPC wraps to 0, then pc 0
        step(8'd18, 1'b0, 1'b0, 1'b1, 32'hFFFFFFFF, 32'h51, 16'h0, 32'h0, 32'h0, 1'b1, 1'b1);
        step(8'd19, 1'b0, 1'b0, 1'b0, 32'h0,  32'hFFFFFFFF, 16'h7777, 32'hFFFFFFFF, 32'h0, 1'b0, 1'b0);
        emit(8'd20, 32'h0, 16'h0010);
        // Reset in RUN with a pending redirect: redirect lost, boot restarts
        step(8'd21, 1'b1, 1'b0, 1'b1, 32'h40, 32'h1,  16'h0, 32'h0, 32'h0, 1'b1, 1'b1);
        step(8'd22, 1'b0, 1'b0, 1'b0, 32'h0,  32'h0,  16'h0, 32'h0, 32'h0, 1'b1, 1'b0);
        step(8'd23, 1'b0, 1'b0, 1'b0, 32'h0,  32'h1,  16'h0, 32'h0, 32'h0, 1'b1, 1'b0);
        emit(8'd24, 32'h10, 16'h1111);
        emit(8'd25, 32'h11, 16'h2222);

        // Let the monitor drain, bounded
        for (int i = 0; i < 4 && sb_q.size() > 0; i++) @(negedge clk);
        checks++;
        if (sb_q.size() != 0) begin
            errors++;
            $display("FAIL drain actual %0d pending entries required 0", sb_q.size());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
